// File: rtl/matrix_key_scanner_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
//  ROWS/COLS   keypad geometry
//  NKEYS       number of keys; key bit index = row*COLS + col
//  KEY_*       one-hot key constants (also consumed by the mode controller)
//  is_onehot   exactly one bit set
//  onehot_index  bit position of a one-hot vector
package matrix_key_scanner_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NKEYS = ROWS * COLS;

  localparam logic [NKEYS-1:0] KEY_1    = 16'h0001;
  localparam logic [NKEYS-1:0] KEY_2    = 16'h0002;
  localparam logic [NKEYS-1:0] KEY_3    = 16'h0004;
  localparam logic [NKEYS-1:0] KEY_A    = 16'h0008;
  localparam logic [NKEYS-1:0] KEY_4    = 16'h0010;
  localparam logic [NKEYS-1:0] KEY_5    = 16'h0020;
  localparam logic [NKEYS-1:0] KEY_6    = 16'h0040;
  localparam logic [NKEYS-1:0] KEY_B    = 16'h0080;
  localparam logic [NKEYS-1:0] KEY_7    = 16'h0100;
  localparam logic [NKEYS-1:0] KEY_8    = 16'h0200;
  localparam logic [NKEYS-1:0] KEY_9    = 16'h0400;
  localparam logic [NKEYS-1:0] KEY_C    = 16'h0800;
  localparam logic [NKEYS-1:0] KEY_STAR = 16'h1000;
  localparam logic [NKEYS-1:0] KEY_0    = 16'h2000;
  localparam logic [NKEYS-1:0] KEY_HASH = 16'h4000;
  localparam logic [NKEYS-1:0] KEY_D    = 16'h8000;

  function automatic logic is_onehot(input logic [NKEYS-1:0] v);
    return (v != '0) && ((v & (v - NKEYS'(1))) == '0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [NKEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NKEYS; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/matrix_key_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//  clk    system clock
//  rst_n  async active-low reset; both stages load RST_VAL
//  d      asynchronous input
//  q      synchronized output (2 clk latency)
module matrix_key_scanner_sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// 4x4 active-low matrix keypad scanner with frame debounce and single-key press pulses.
//  clk        system clock
//  rst_n      async active-low reset
//  col        keypad columns (pulled up; 0 = closed key in the strobed row)
//  row        keypad rows, exactly one low at a time
//  key_pulse  one-hot, one clk per accepted clean single-key press
//  key_state  debounced level of all 16 keys (1 = held)
//  key_code   index of the last pulsed key, held between presses
//  key_valid  high together with key_pulse
module matrix_key_scanner
  import matrix_key_scanner_pkg::*;
#(
  parameter int ROW_DWELL       = 12000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  col,
  output logic [ROWS-1:0]  row,
  output logic [NKEYS-1:0] key_pulse,
  output logic [NKEYS-1:0] key_state,
  output logic [3:0]       key_code,
  output logic             key_valid
);

  localparam int DW = $clog2(ROW_DWELL);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] STABLE_PRE = SW'(DEBOUNCE_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Column synchronizer. Idle columns read high, so reset the flops high to
  // avoid a phantom "all closed" sample right after reset.
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_sync;
  logic [COLS-1:0] closed;

  matrix_key_scanner_sync_2ff #(
    .WIDTH   (COLS),
    .RST_VAL ('1)
  ) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col),
    .q     (col_sync)
  );

  assign closed = ~col_sync;

  // ---------------------------------------------------------------------------
  // Row scan. The columns are sampled on the last dwell cycle so the
  // synchronizer has long settled on the current row.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic          dwell_tc;
  logic          frame_done;

  assign dwell_tc   = (dwell_cnt == DWELL_LAST);
  assign frame_done = dwell_tc && (row_idx == 2'd3);
  assign row        = ~(ROWS'(1) << row_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
    end else if (dwell_tc) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot. `frame` is the snapshot with the current row's slice replaced by
  // the live sample, so on frame_done it already contains the row-3 bits.
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] snapshot;
  logic [NKEYS-1:0] frame;

  always_comb begin
    frame = snapshot;
    frame[row_idx*COLS +: COLS] = closed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        snapshot <= '0;
    else if (dwell_tc) snapshot <= frame;
  end

  // ---------------------------------------------------------------------------
  // Debounce across frames. Accept fires only on the DEBOUNCE_FRAMES-1 ->
  // DEBOUNCE_FRAMES transition, so a held pattern is accepted once.
  // ---------------------------------------------------------------------------
  logic [SW-1:0]    stable_cnt;
  logic [NKEYS-1:0] prev_frame;
  logic             same_frame;
  logic             accept;

  assign same_frame = (frame == prev_frame);
  assign accept     = frame_done && same_frame && (stable_cnt == STABLE_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      prev_frame <= '0;
      key_state  <= '0;
    end else if (frame_done) begin
      prev_frame <= frame;
      if (!same_frame)                stable_cnt <= '0;
      else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SW'(1);
      if (accept) key_state <= frame;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse generation, one cycle after accept. A pulse needs the previously
  // accepted state to be idle, which gives ghost rejection, no pulse on
  // release / roll-over, and guaranteed idle gaps between pulses.
  // ---------------------------------------------------------------------------
  logic accept_q;
  logic was_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q <= 1'b0;
      was_idle <= 1'b0;
    end else begin
      accept_q <= accept;
      if (accept) was_idle <= (key_state == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pulse <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else if (accept_q && was_idle && is_onehot(key_state)) begin
      key_pulse <= key_state;
      key_valid <= 1'b1;
      key_code  <= onehot_index(key_state);
    end else begin
      key_pulse <= '0;
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_key_scanner.sv
module tb_matrix_key_scanner;
  import matrix_key_scanner_pkg::*;

  localparam int D  = 4;
  localparam int DF = 3;
  localparam int F  = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_pulse, key_state;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys = '0;  // pressed keys on the physical pad

  int checks = 0, errors = 0, cyc = 0;
  int pcnt = 0, pcyc = -1000;
  logic [15:0] plast = '0;
  logic [3:0]  pcode = '0;

  always #5 clk = ~clk;

  // Keypad: a closed key shorts its column to its row while that row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  matrix_key_scanner #(.ROW_DWELL(D), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row),
    .key_pulse(key_pulse), .key_state(key_state),
    .key_code(key_code), .key_valid(key_valid));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, driven by the edge count since reset release.
  // Edge n samples row ((n-1)/D)%4 when n%D==0, seeing the pad as it was two
  // edges earlier (synchronizer). Every 4th sample closes a frame; a frame is
  // accepted when it has matched its predecessor DF times in a row. The pulse
  // shows up one edge after the accept.
  // ---------------------------------------------------------------------------
  int          mn = 0, streak = 0;
  logic [15:0] p1 = '0, p2 = '0, snap = '0, last_frame = '0;
  logic [15:0] m_state = '0, m_pulse = '0;
  logic [3:0]  m_code = '0, m_row = 4'b1110;
  logic        m_valid = 1'b0, pend = 1'b0, was_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn = 0; streak = 0; p1 = '0; p2 = '0; snap = '0; last_frame = '0;
      m_state = '0; m_pulse = '0; m_code = '0; m_valid = 1'b0;
      pend = 1'b0; was_zero = 1'b0; m_row = 4'b1110;
    end else begin
      m_pulse = '0;
      m_valid = 1'b0;
      if (pend && was_zero && $countones(m_state) == 1) begin
        m_pulse = m_state;
        m_valid = 1'b1;
        for (int i = 0; i < 16; i++) if (m_state[i]) m_code = 4'(i);
      end
      pend = 1'b0;
      mn++;
      if (mn % D == 0) begin
        int r;
        r = ((mn - 1) / D) % 4;
        snap[r*4 +: 4] = p2[r*4 +: 4];
        if (r == 3) begin
          if (snap == last_frame) streak++;
          else streak = 0;
          last_frame = snap;
          if (streak == DF) begin
            pend = 1'b1;
            was_zero = (m_state == '0);
            m_state = snap;
          end
        end
      end
      p2 = p1;
      p1 = keys;
      m_row = ~(4'b0001 << ((mn / D) % 4));
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    check("row",       16'(row),       16'(m_row));
    check("key_pulse", key_pulse,      m_pulse);
    check("key_state", key_state,      m_state);
    check("key_code",  16'(key_code),  16'(m_code));
    check("key_valid", 16'(key_valid), 16'(m_valid));
    if (key_valid) begin
      pcnt++;
      plast = key_pulse;
      pcode = key_code;
      pcyc  = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Return just after a frame-closing edge, i.e. at the start of a new frame.
  task automatic align_frame();
    int guard;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((mn % F) != 0 && guard < 2 * F);
    check("align_frame", 16'(mn % F), 16'd0);
  endtask

  task automatic clear_pulses();
    pcnt = 0;
    pcyc = -1000;
    plast = '0;
  endtask

  initial begin
    logic [3:0] rtbl [4];
    int t0, lat, sel, hold;
    logic [15:0] pat;
    rtbl[0] = 4'b1110; rtbl[1] = 4'b1101; rtbl[2] = 4'b1011; rtbl[3] = 4'b0111;

    // Reset values
    @(negedge clk);
    check("rst_row",   16'(row),       16'h000E);
    check("rst_pulse", key_pulse,      16'h0000);
    check("rst_state", key_state,      16'h0000);
    check("rst_code",  16'(key_code),  16'h0000);
    check("rst_valid", 16'(key_valid), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. Row sequence, 4 cycles per row
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("t1_row",   16'(row), 16'(rtbl[(i / 4) % 4]));
      check("t1_state", key_state, 16'h0000);
      @(posedge clk);
    end
    #1;

    // 2. Clean hold of A
    align_frame();
    clear_pulses();
    keys = KEY_A;
    t0 = cyc;
    wait_cycles(8 * F);
    lat = pcyc - t0;
    check("t2_count", 16'(pcnt), 16'd1);
    check("t2_pulse", plast, 16'h0008);
    check("t2_code",  16'(pcode), 16'd3);
    check("t2_state", key_state, 16'h0008);
    check("t2_latency_in_window", 16'(lat >= 3 * F && lat <= 4 * F + 3), 16'd1);
    keys = '0;
    wait_cycles(6 * F);
    check("t2_release_state", key_state, 16'h0000);
    check("t2_release_nopulse", 16'(pcnt), 16'd1);

    // 3. Bouncing 5, then settled
    align_frame();
    clear_pulses();
    for (int i = 0; i < 8; i++) begin
      keys = keys ^ KEY_5;
      wait_cycles(6);
    end
    check("t3_bounce_nopulse", 16'(pcnt), 16'd0);
    keys = KEY_5;
    t0 = cyc;
    wait_cycles(8 * F);
    lat = pcyc - t0;
    check("t3_count", 16'(pcnt), 16'd1);
    check("t3_pulse", plast, 16'h0020);
    check("t3_code",  16'(pcode), 16'd5);
    check("t3_latency_in_window", 16'(lat >= 3 * F && lat <= 4 * F + 3), 16'd1);
    keys = '0;
    wait_cycles(6 * F);

    // 4. D, D+C, C, none
    align_frame();
    clear_pulses();
    keys = KEY_D;
    wait_cycles(6 * F);
    check("t4_pulse", plast, 16'h8000);
    check("t4_code",  16'(pcode), 16'd15);
    keys = KEY_D | KEY_C;
    wait_cycles(6 * F);
    check("t4_state_dc", key_state, 16'h8800);
    keys = KEY_C;
    wait_cycles(6 * F);
    check("t4_state_c", key_state, 16'h0800);
    keys = '0;
    wait_cycles(6 * F);
    check("t4_state_none", key_state, 16'h0000);
    check("t4_count", 16'(pcnt), 16'd1);

    // 5. Ghost pair rejected, then a clean 0
    align_frame();
    clear_pulses();
    keys = KEY_1 | KEY_HASH;
    wait_cycles(6 * F);
    check("t5_state_pair", key_state, 16'h4001);
    check("t5_pair_nopulse", 16'(pcnt), 16'd0);
    keys = '0;
    wait_cycles(6 * F);
    keys = KEY_0;
    wait_cycles(6 * F);
    check("t5_count", 16'(pcnt), 16'd1);
    check("t5_pulse", plast, 16'h2000);
    check("t5_code",  16'(pcode), 16'd13);

    // 6. Reset mid-frame with 7 held
    keys = KEY_7;
    wait_cycles(2 * F + 5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_row",   16'(row),       16'h000E);
    check("t6_rst_pulse", key_pulse,      16'h0000);
    check("t6_rst_state", key_state,      16'h0000);
    check("t6_rst_code",  16'(key_code),  16'h0000);
    check("t6_rst_valid", 16'(key_valid), 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_pulses();
    wait_cycles(8 * F);
    check("t6_count", 16'(pcnt), 16'd1);
    check("t6_pulse", plast, 16'h0100);
    check("t6_code",  16'(pcode), 16'd8);
    keys = '0;
    wait_cycles(6 * F);

    // Random presses at random phases: singles, pairs, short glitches
    for (int it = 0; it < 14; it++) begin
      wait_cycles($urandom_range(F, 3 * F));
      sel = $urandom_range(0, 9);
      pat = 16'h0001 << $urandom_range(0, 15);
      if (sel >= 6 && sel < 8) pat = pat | (16'h0001 << $urandom_range(0, 15));
      hold = (sel >= 8) ? $urandom_range(2, 10) : $urandom_range(2 * F, 8 * F);
      keys = pat;
      wait_cycles(hold);
      if ($urandom_range(0, 2) == 0) begin
        keys = pat | (16'h0001 << $urandom_range(0, 15));
        wait_cycles($urandom_range(F, 6 * F));
      end
      keys = '0;
      wait_cycles(6 * F);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
